// File: rtl/play_sequencer_if.sv
// play_sequencer_if: board-side inputs and renderer-side outputs of the play sequencer
// master drives the board inputs (start, speed, song, press, ticks, flags) and reads status;
// slave is the sequencer, which reads the inputs and drives state, head position, progress and strobes.
interface play_sequencer_if;
  logic        move_tick;
  logic        audio_tick;
  logic        play_signal;
  logic        restart;
  logic [2:0]  speed;
  logic [1:0]  song;
  logic        press;
  logic        fail_in;
  logic        debug_switch;
  logic [2:0]  state;
  logic [16:0] head_x_raw;
  logic [16:0] head_y_raw;
  logic        direction;
  logic [9:0]  progress;
  logic [1:0]  countdown;
  logic        load_map;
  logic        failed;
  logic        song_done;
  logic [1:0]  song_lat;
  modport master (
    output move_tick, audio_tick, play_signal, restart, speed, song, press, fail_in, debug_switch,
    input  state, head_x_raw, head_y_raw, direction, progress, countdown, load_map, failed, song_done, song_lat
  );
  modport slave (
    input  move_tick, audio_tick, play_signal, restart, speed, song, press, fail_in, debug_switch,
    output state, head_x_raw, head_y_raw, direction, progress, countdown, load_map, failed, song_done, song_lat
  );
endinterface

// File: rtl/play_sequencer.sv
// play_sequencer: run-time sequencing of one game session (countdown, play/pause, head motion, turns, progress, fail/done)
// Ports: clk, reset (async active-high); bus (slave) carries the board inputs and the
// state/head/direction/progress/countdown/load_map/failed/song_done/song_lat outputs.
module play_sequencer #(
  parameter int HEAD_X0       = 672,
  parameter int HEAD_Y0       = 480,
  parameter int TURN_MIN_X    = 697,
  parameter int TICKS_PER_SEC = 128,
  parameter int CD_SECS       = 3,
  parameter int PROG_MAX      = 1000
) (
  input logic clk,
  input logic reset,
  play_sequencer_if.slave bus
);
  localparam int TW = $clog2(TICKS_PER_SEC) + 1;
  typedef enum logic [2:0] {IDLE = 3'd0, COUNTDOWN = 3'd1, PLAYING = 3'd2, PAUSED = 3'd3, FAILED = 3'd4, DONE = 3'd5} state_t;
  state_t state_q, state_d;
  logic [16:0] hx_q, hx_d, hy_q, hy_d;
  logic dir_q, dir_d;
  logic [9:0] prog_q, prog_d;
  logic [1:0] cd_q, cd_d, song_q, song_d;
  logic [15:0] acc_q, acc_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] step;
  logic [16:0] thr, sum;
  logic pend_fail, pend_done;
  assign step = bus.speed == 3'd0 ? 4'd0 : bus.speed == 3'd7 ? 4'd12 : {1'b0, bus.speed} + 4'd4;
  assign thr = bus.song_lat == 2'd0 ? 17'd35376 : bus.song_lat == 2'd1 ? 17'd29370 :
               bus.song_lat == 2'd2 ? 17'd19393 : 17'd18338;
  assign sum = {1'b0, acc_q} + 17'(step);
  assign pend_fail = bus.fail_in & ~bus.debug_switch;
  // progress is registered, so DONE follows one clk after it reaches PROG_MAX
  assign pend_done = prog_q == 10'(PROG_MAX);
  always_comb begin
    state_d = state_q;
    hx_d = hx_q;
    hy_d = hy_q;
    dir_d = dir_q;
    prog_d = prog_q;
    cd_d = cd_q;
    song_d = song_q;
    acc_d = acc_q;
    tick_d = tick_q;
    case (state_q)
      IDLE: begin
        song_d = bus.song;
        if (bus.play_signal) begin
          state_d = COUNTDOWN;
          cd_d = 2'(CD_SECS);
          tick_d = '0;
        end
      end
      COUNTDOWN: begin
        if (bus.move_tick) begin
          tick_d = tick_q == TW'(TICKS_PER_SEC - 1) ? '0 : tick_q + 1'b1;
          if (tick_q == TW'(TICKS_PER_SEC - 1)) begin
            cd_d = cd_q - 2'd1;
            state_d = cd_q == 2'd1 ? PLAYING : COUNTDOWN;
          end
        end
      end
      PLAYING: begin
        // a turn taken in the same clk as a move steers that move
        dir_d = (bus.press && hx_q >= 17'(TURN_MIN_X)) ? ~dir_q : dir_q;
        if (bus.move_tick) begin
          hx_d = dir_d ? hx_q : hx_q + 17'(step);
          hy_d = dir_d ? hy_q + 17'(step) : hy_q;
        end
        // incremental divide: acc accumulates step per audio tick, one progress unit per T
        if (bus.audio_tick && !pend_done) begin
          acc_d = sum >= thr ? 16'(sum - thr) : sum[15:0];
          prog_d = sum >= thr ? prog_q + 10'd1 : prog_q;
        end
        state_d = pend_fail ? FAILED : pend_done ? DONE : bus.speed == 3'd0 ? PAUSED : PLAYING;
      end
      PAUSED: state_d = bus.speed != 3'd0 ? PLAYING : PAUSED;
      FAILED, DONE: begin
        if (bus.restart) begin
          state_d = IDLE;
          hx_d = 17'(HEAD_X0);
          hy_d = 17'(HEAD_Y0);
          dir_d = 1'b0;
          prog_d = '0;
          acc_d = '0;
          cd_d = '0;
          tick_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hx_q <= 17'(HEAD_X0);
      hy_q <= 17'(HEAD_Y0);
      dir_q <= 1'b0;
      prog_q <= '0;
      cd_q <= '0;
      song_q <= '0;
      acc_q <= '0;
      tick_q <= '0;
    end else begin
      state_q <= state_d;
      hx_q <= hx_d;
      hy_q <= hy_d;
      dir_q <= dir_d;
      prog_q <= prog_d;
      cd_q <= cd_d;
      song_q <= song_d;
      acc_q <= acc_d;
      tick_q <= tick_d;
    end
  end
  assign bus.state = state_q;
  assign bus.head_x_raw = hx_q;
  assign bus.head_y_raw = hy_q;
  assign bus.direction = dir_q;
  assign bus.progress = prog_q;
  assign bus.countdown = cd_q;
  assign bus.song_lat = song_q;
  assign bus.load_map = state_q == IDLE;
  assign bus.failed = state_q == FAILED;
  assign bus.song_done = state_q == DONE;
endmodule

// File: tb/tb_play_sequencer.sv
// tb_play_sequencer: directed checks of countdown, motion, turns, progress, pause, fail/done and reset
module tb_play_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  play_sequencer_if bus();
  play_sequencer #(.TICKS_PER_SEC(4), .PROG_MAX(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic tick(input int n);
    bus.move_tick = 1'b1;
    cyc(n);
    bus.move_tick = 1'b0;
  endtask
  task automatic pulse_restart();
    bus.restart = 1'b1;
    cyc(1);
    bus.restart = 1'b0;
  endtask
  task automatic start_game();
    bus.speed = 3'd7;
    bus.play_signal = 1'b1;
    cyc(1);
    bus.play_signal = 1'b0;
    tick(12);
    chk("start_state", 32'(bus.state), 2);
  endtask
  task automatic run_to_max(output int n);
    n = 0;
    bus.audio_tick = 1'b1;
    while (bus.progress != 10'd10 && n < 40000) begin
      cyc(1);
      n++;
    end
    bus.audio_tick = 1'b0;
    chk("prog_max", 32'(bus.progress), 10);
  endtask
  int n;
  initial begin
    bus.move_tick = 0; bus.audio_tick = 0; bus.play_signal = 0; bus.restart = 0;
    bus.speed = 0; bus.song = 0; bus.press = 0; bus.fail_in = 0; bus.debug_switch = 0;
    #12;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_x", 32'(bus.head_x_raw), 672);
    chk("rst_y", 32'(bus.head_y_raw), 480);
    chk("rst_flags", {bus.direction, bus.load_map, bus.failed, bus.song_done}, 4'b0100);
    chk("rst_prog_cd", {bus.progress, bus.countdown, bus.song_lat}, 0);
    reset = 1'b0;
    bus.song = 2'd3;
    cyc(1);
    chk("song_track", 32'(bus.song_lat), 3);
    bus.speed = 3'd1;
    bus.play_signal = 1'b1;
    cyc(1);
    bus.play_signal = 1'b0;
    bus.song = 2'd0;
    chk("cd_enter", {29'(bus.state), bus.countdown}, {29'd1, 2'd3});
    tick(4);
    chk("cd_2", 32'(bus.countdown), 2);
    tick(4);
    chk("cd_1", 32'(bus.countdown), 1);
    tick(3);
    chk("cd_11", {29'(bus.state), bus.countdown}, {29'd1, 2'd1});
    tick(1);
    chk("cd_play", {29'(bus.state), bus.countdown}, {29'd2, 2'd0});
    chk("cd_x", 32'(bus.head_x_raw), 672);
    chk("song_frozen", 32'(bus.song_lat), 3);
    tick(4);
    chk("x_692", 32'(bus.head_x_raw), 692);
    bus.press = 1'b1;
    cyc(1);
    bus.press = 1'b0;
    chk("press_low", 32'(bus.direction), 0);
    tick(1);
    chk("x_697", 32'(bus.head_x_raw), 697);
    bus.press = 1'b1;
    tick(1);
    bus.press = 1'b0;
    chk("turn_dir", 32'(bus.direction), 1);
    chk("turn_y", 32'(bus.head_y_raw), 485);
    chk("turn_x", 32'(bus.head_x_raw), 697);
    bus.speed = 3'd4;
    bus.audio_tick = 1'b1;
    cyc(18337);
    chk("prog_7", 32'(bus.progress), 7);
    cyc(1);
    bus.audio_tick = 1'b0;
    chk("prog_8", 32'(bus.progress), 8);
    chk("acc_0", 32'(dut.acc_q), 0);
    bus.speed = 3'd0;
    cyc(1);
    chk("pause", 32'(bus.state), 3);
    bus.move_tick = 1; bus.audio_tick = 1; bus.press = 1; bus.fail_in = 1;
    cyc(100);
    bus.move_tick = 0; bus.audio_tick = 0; bus.press = 0; bus.fail_in = 0;
    chk("pause_state", 32'(bus.state), 3);
    chk("pause_pos", {bus.head_x_raw, bus.head_y_raw}, {17'd697, 17'd485});
    chk("pause_prog", {bus.progress, bus.direction}, {10'd8, 1'b1});
    bus.speed = 3'd2;
    cyc(1);
    chk("resume", 32'(bus.state), 2);
    bus.speed = 3'd7;
    run_to_max(n);
    chk("done_ticks", 32'(n), 3057);
    chk("done_pending", 32'(bus.state), 2);
    cyc(1);
    chk("done_state", 32'(bus.state), 5);
    chk("done_flags", {bus.song_done, bus.failed, bus.load_map}, 3'b100);
    bus.play_signal = 1'b1;
    cyc(1);
    bus.play_signal = 1'b0;
    chk("done_play", 32'(bus.state), 5);
    pulse_restart();
    chk("restart_state", 32'(bus.state), 0);
    chk("restart_pos", {bus.head_x_raw, bus.head_y_raw}, {17'd672, 17'd480});
    chk("restart_prog", {bus.progress, bus.direction, bus.load_map}, {10'd0, 1'b0, 1'b1});
    cyc(1);
    start_game();
    tick(10);
    chk("s7_x", 32'(bus.head_x_raw), 792);
    chk("s7_y", 32'(bus.head_y_raw), 480);
    pulse_restart();
    chk("restart_ign", 32'(bus.state), 2);
    run_to_max(n);
    bus.fail_in = 1'b1;
    cyc(1);
    bus.fail_in = 1'b0;
    chk("fail_wins", 32'(bus.state), 4);
    chk("fail_flag", {bus.failed, bus.song_done}, 2'b10);
    chk("fail_hold", 32'(bus.head_x_raw), 792);
    bus.play_signal = 1'b1;
    cyc(1);
    bus.play_signal = 1'b0;
    chk("fail_play", 32'(bus.state), 4);
    pulse_restart();
    chk("fail_restart", 32'(bus.state), 0);
    bus.debug_switch = 1'b1;
    start_game();
    run_to_max(n);
    bus.fail_in = 1'b1;
    cyc(1);
    bus.fail_in = 1'b0;
    bus.debug_switch = 1'b0;
    chk("dbg_done", 32'(bus.state), 5);
    pulse_restart();
    start_game();
    tick(3);
    chk("pre_rst_x", 32'(bus.head_x_raw), 708);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_x", 32'(bus.head_x_raw), 672);
    chk("arst_flags", {bus.load_map, bus.countdown}, 3'b100);
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
